// File: rtl/transpad_gen.sv
// transpad_gen: interleaved strided-stream predictor with an inner/outer loop nest,
// mapping matching lookup addresses to sequential scratchpad addresses.
// Optional miss counter output enabled by defining TRANSPAD_GEN_MISS_CNT_EN.
module transpad_gen #(
   parameter int AW = 48,
   parameter int SW = 24,
   parameter int FW = 16,
   parameter int NS = 4,
   localparam int IW = (NS > 1) ? $clog2(NS) : 1
) (
   input  logic          clk,
   input  logic          rstn,
   input  logic [2:0]    cmd,
   input  logic [AW-1:0] data,
   input  logic          rdy,
   output logic          spm,
   output logic [SW-1:0] out,
   output logic          busy,
   output logic          done,
   output logic          err
`ifdef TRANSPAD_GEN_MISS_CNT_EN
   ,output logic [FW-1:0] miss_cnt
`endif
);

   typedef enum logic [1:0] {IDLE, INIT, RUN, DONE} state_t;

   localparam logic [7:0] NS8 = 8'(NS);

   state_t        state, state_nxt;

   logic [AW-1:0] st_addr;
   logic [7:0]    nstr;
   logic [FW-1:0] len, oofs, olen;
   logic [FW-1:0] str [NS];
   logic [FW-1:0] ofs [NS];

   logic [AW-1:0] base;
   logic [AW-1:0] tgt [NS];
   logic [SW-1:0] spad;
   logic [IW-1:0] cur;
   logic [FW-1:0] icnt, ocnt;
   logic [AW-1:0] lst_addr;
   logic [SW-1:0] lst_spad;
   logic          lst_vld;

   logic          cfg_beat, cfg_ok, lookup, is_start, is_stop;
   logic          params_ok, start_ok, err_nxt;
   logic          tgt_hit, lst_hit, cur_last, inner_end, outer_end;
   logic [AW-1:0] base_nxt;
   logic [IW-1:0] k_idx;

   // Beat decode
   assign cfg_beat  = rdy && (cmd <= 3'd3);
   assign lookup    = rdy && (cmd == 3'd6);
   assign is_start  = rdy && (cmd == 3'd7) && (data[7:0] == 8'hA5);
   assign is_stop   = rdy && (cmd == 3'd7) && (data[7:0] == 8'h5A);
   assign cfg_ok    = (state == IDLE) || (state == DONE);
   assign params_ok = (nstr != 8'd0) && (nstr <= NS8) && (len != '0) && (olen != '0);
   assign start_ok  = is_start && cfg_ok && params_ok;
   assign err_nxt   = (cfg_beat && !cfg_ok) || (is_start && !start_ok);
   assign k_idx     = data[2*FW+IW-1:2*FW];

   // Hit detection and loop-end conditions for the current target
   assign tgt_hit   = lookup && (state == RUN) && (data == tgt[cur]);
   assign lst_hit   = lookup && lst_vld && (data == lst_addr);
   assign cur_last  = (8'(cur) == (nstr - 8'd1));
   assign inner_end = tgt_hit && cur_last && ((icnt + FW'(1)) == len);
   assign outer_end = inner_end && ((ocnt + FW'(1)) == olen);
   assign base_nxt  = base + AW'(oofs);

   assign busy = (state == INIT) || (state == RUN);
   assign done = (state == DONE);

   // NOTE: every variable written here gets a default first, so no path can infer a latch.
   always_comb begin
      spm = 1'b0;
      out = '0;
      if (tgt_hit) begin
         spm = 1'b1;
         out = spad;
      end else if (lst_hit) begin
         spm = 1'b1;
         out = lst_spad;
      end
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE, DONE: if (start_ok) state_nxt = INIT;
         INIT:       state_nxt = RUN;
         RUN:        if (outer_end) state_nxt = DONE;
         default:    state_nxt = IDLE;
      endcase
      if (is_stop) state_nxt = IDLE;
   end

   // NOTE: sequential state uses non-blocking assignments so every register updates from pre-edge values.
   always_ff @(posedge clk) begin
      if (!rstn) state <= IDLE;
      else       state <= state_nxt;
   end

   always_ff @(posedge clk) begin
      if (!rstn) begin
         st_addr  <= '0;
         nstr     <= '0;
         len      <= '0;
         oofs     <= '0;
         olen     <= '0;
         base     <= '0;
         spad     <= '0;
         cur      <= '0;
         icnt     <= '0;
         ocnt     <= '0;
         lst_addr <= '0;
         lst_spad <= '0;
         lst_vld  <= 1'b0;
         err      <= 1'b0;
         // NOTE: the per-stream arrays are reset explicitly; they are small register files, not RAM.
         for (int k = 0; k < NS; k++) begin
            str[k] <= '0;
            ofs[k] <= '0;
            tgt[k] <= '0;
         end
      end else begin
         err <= err_nxt;

         if (cfg_beat && cfg_ok) begin
            case (cmd)
               3'd0: st_addr <= data;
               3'd1: begin
                  nstr <= data[FW+7:FW];
                  len  <= data[FW-1:0];
               end
               3'd2: begin
                  oofs <= data[2*FW-1:FW];
                  olen <= data[FW-1:0];
               end
               default: begin
                  // Indices at or above NS match no entry and are dropped
                  for (int k = 0; k < NS; k++) begin
                     if (k_idx == IW'(k)) begin
                        str[k] <= data[2*FW-1:FW];
                        ofs[k] <= data[FW-1:0];
                     end
                  end
               end
            endcase
         end

         if (start_ok) begin
            base    <= st_addr;
            spad    <= '0;
            cur     <= '0;
            icnt    <= '0;
            ocnt    <= '0;
            lst_vld <= 1'b0;
         end

         if (is_stop) lst_vld <= 1'b0;

         if (state == INIT) begin
            for (int k = 0; k < NS; k++) tgt[k] <= base + AW'(ofs[k]);
         end

         if (tgt_hit) begin
            lst_addr <= tgt[cur];
            lst_spad <= spad;
            lst_vld  <= 1'b1;
            tgt[cur] <= tgt[cur] + AW'(str[cur]);
            spad     <= spad + SW'(1);
            if (cur_last) begin
               cur  <= '0;
               icnt <= icnt + FW'(1);
            end else begin
               cur  <= cur + IW'(1);
            end
            // Outer step: later reload assignments override the stride advance above
            if (inner_end) begin
               icnt <= '0;
               ocnt <= ocnt + FW'(1);
               base <= base_nxt;
               if (!outer_end) begin
                  for (int k = 0; k < NS; k++) tgt[k] <= base_nxt + AW'(ofs[k]);
               end
            end
         end
      end
   end

`ifdef TRANSPAD_GEN_MISS_CNT_EN
   always_ff @(posedge clk) begin
      if (!rstn)
         miss_cnt <= '0;
      else if (start_ok)
         miss_cnt <= '0;
      else if (lookup && (state == RUN) && !spm && (miss_cnt != '1))
         miss_cnt <= miss_cnt + FW'(1);
   end
`endif

endmodule

// File: tb/tb_transpad_gen.sv
// Directed self-checking bench for transpad_gen; lookup results go through an
// expected-value queue, registered status is checked one step after each beat.
module tb_transpad_gen;

   localparam int AW = 48;
   localparam int SW = 24;
   localparam int FW = 16;
   localparam int NS = 4;

   logic          clk = 1'b0;
   logic          rstn;
   logic [2:0]    cmd;
   logic [AW-1:0] data;
   logic          rdy;
   logic          spm;
   logic [SW-1:0] out;
   logic          busy, done, err;
`ifdef TRANSPAD_GEN_MISS_CNT_EN
   logic [FW-1:0] miss_cnt;
`endif

   int checks = 0;
   int errors = 0;
   logic [SW:0] sb [$];

   transpad_gen #(.AW(AW), .SW(SW), .FW(FW), .NS(NS)) dut (
      .clk  (clk),
      .rstn (rstn),
      .cmd  (cmd),
      .data (data),
      .rdy  (rdy),
      .spm  (spm),
      .out  (out),
      .busy (busy),
      .done (done),
      .err  (err)
`ifdef TRANSPAD_GEN_MISS_CNT_EN
      ,.miss_cnt (miss_cnt)
`endif
   );

   always #5 clk = ~clk;

   initial begin
      #1_000_000;
      $display("FAIL watchdog: observed timeout expected finish");
      $fatal(1, "simulation time limit exceeded");
   end

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic beat(input logic [2:0] c, input logic [AW-1:0] d);
      cmd  = c;
      data = d;
      rdy  = 1'b1;
      @(posedge clk);
      #1;
      rdy  = 1'b0;
      cmd  = 3'd0;
      data = '0;
   endtask

   task automatic idle_cycle();
      @(posedge clk);
      #1;
   endtask

   task automatic lookup(input string tag, input logic [AW-1:0] a,
                         input logic s, input logic [SW-1:0] o);
      logic [SW:0] e;
      sb.push_back({s, o});
      cmd  = 3'd6;
      data = a;
      rdy  = 1'b1;
      @(negedge clk);
      e = sb.pop_front();
      check({tag, ".spm"}, 64'(spm), 64'(e[SW]));
      check({tag, ".out"}, 64'(out), 64'(e[SW-1:0]));
      @(posedge clk);
      #1;
      rdy  = 1'b0;
      cmd  = 3'd0;
      data = '0;
   endtask

   task automatic status(input string tag, input logic b, input logic d, input logic e);
      check({tag, ".busy"}, 64'(busy), 64'(b));
      check({tag, ".done"}, 64'(done), 64'(d));
      check({tag, ".err"},  64'(err),  64'(e));
   endtask

   initial begin
      rstn = 1'b0;
      rdy  = 1'b0;
      cmd  = 3'd0;
      data = '0;
      repeat (2) @(posedge clk);
      #1;
      status("reset", 1'b0, 1'b0, 1'b0);
      check("reset.spm", 64'(spm), 64'd0);
      check("reset.out", 64'(out), 64'd0);
`ifdef TRANSPAD_GEN_MISS_CNT_EN
      check("reset.miss", 64'(miss_cnt), 64'd0);
`endif
      rstn = 1'b1;
      idle_cycle();

      // Two interleaved streams, one outer iteration
      beat(3'd0, 48'h0000_0000_1000);
      beat(3'd1, 48'h0000_0002_0002);
      beat(3'd2, 48'h0000_0000_0001);
      beat(3'd3, 48'h0000_0004_0000);
      beat(3'd3, 48'h0001_0008_0100);
      beat(3'd7, 48'h0000_0000_00A5);
      status("t1.start", 1'b1, 1'b0, 1'b0);
      lookup("t1.init", 48'h1000, 1'b0, 24'd0);
      lookup("t1.h0", 48'h1000, 1'b1, 24'd0);
      lookup("t1.h1", 48'h1100, 1'b1, 24'd1);
      lookup("t1.h2", 48'h1004, 1'b1, 24'd2);
      status("t1.mid", 1'b1, 1'b0, 1'b0);
      lookup("t1.h3", 48'h1108, 1'b1, 24'd3);
      status("t1.end", 1'b0, 1'b1, 1'b0);
      lookup("t1.done_last", 48'h1108, 1'b1, 24'd3);
      lookup("t1.done_miss", 48'h1004, 1'b0, 24'd0);

      // Out-of-order lookup, last-hit replay, stop and restart
      beat(3'd7, 48'h0000_0000_00A5);
      idle_cycle();
      lookup("t2.ooo", 48'h1100, 1'b0, 24'd0);
      lookup("t2.h0", 48'h1000, 1'b1, 24'd0);
      lookup("t2.rep", 48'h1000, 1'b1, 24'd0);
      beat(3'd7, 48'h0000_0000_005A);
      status("t2.stop", 1'b0, 1'b0, 1'b0);
      lookup("t2.after_stop", 48'h1000, 1'b0, 24'd0);
      beat(3'd7, 48'h0000_0000_00A5);
      idle_cycle();
      lookup("t2.rs0", 48'h1000, 1'b1, 24'd0);
      lookup("t2.rs1", 48'h1100, 1'b1, 24'd1);
      beat(3'd7, 48'h0000_0000_005A);

      // Single stream, two outer iterations
      beat(3'd0, 48'h0);
      beat(3'd1, 48'h0000_0001_0002);
      beat(3'd2, 48'h0000_0040_0002);
      beat(3'd3, 48'h0000_0010_0000);
      beat(3'd7, 48'h0000_0000_00A5);
      idle_cycle();
      lookup("t3.h0", 48'h00, 1'b1, 24'd0);
      lookup("t3.h1", 48'h10, 1'b1, 24'd1);
      lookup("t3.stale", 48'h20, 1'b0, 24'd0);
      lookup("t3.h2", 48'h40, 1'b1, 24'd2);
      status("t3.mid", 1'b1, 1'b0, 1'b0);
      lookup("t3.h3", 48'h50, 1'b1, 24'd3);
      status("t3.end", 1'b0, 1'b1, 1'b0);

      // Rejected starts from IDLE
      beat(3'd7, 48'h0000_0000_005A);
      beat(3'd1, 48'h0000_0000_0002);
      beat(3'd7, 48'h0000_0000_00A5);
      status("t4.nstr0", 1'b0, 1'b0, 1'b1);
      idle_cycle();
      check("t4.err_clear", 64'(err), 64'd0);
      beat(3'd1, 48'h0000_0005_0002);
      beat(3'd7, 48'h0000_0000_00A5);
      status("t4.nstr5", 1'b0, 1'b0, 1'b1);
      beat(3'd1, 48'h0000_0002_0000);
      beat(3'd7, 48'h0000_0000_00A5);
      status("t4.len0", 1'b0, 1'b0, 1'b1);

      // Config and start during RUN are rejected and leave registers intact
      beat(3'd1, 48'h0000_0001_0002);
      beat(3'd2, 48'h0000_0000_0001);
      beat(3'd7, 48'h0000_0000_00A5);
      idle_cycle();
      beat(3'd3, 48'h0000_0020_0000);
      status("t5.cfg_run", 1'b1, 1'b0, 1'b1);
      beat(3'd7, 48'h0000_0000_00A5);
      status("t5.start_run", 1'b1, 1'b0, 1'b1);
      lookup("t5.h0", 48'h00, 1'b1, 24'd0);
      lookup("t5.h1", 48'h10, 1'b1, 24'd1);
      status("t5.end", 1'b0, 1'b1, 1'b0);

      // Misses in RUN, lookup in IDLE, clear on start
      beat(3'd7, 48'h0000_0000_00A5);
`ifdef TRANSPAD_GEN_MISS_CNT_EN
      check("t6.clear", 64'(miss_cnt), 64'd0);
`endif
      idle_cycle();
      lookup("t6.m0", 48'h07, 1'b0, 24'd0);
      lookup("t6.m1", 48'h08, 1'b0, 24'd0);
      lookup("t6.m2", 48'h09, 1'b0, 24'd0);
`ifdef TRANSPAD_GEN_MISS_CNT_EN
      check("t6.three", 64'(miss_cnt), 64'd3);
`endif
      beat(3'd7, 48'h0000_0000_005A);
      lookup("t6.idle", 48'h0A, 1'b0, 24'd0);
`ifdef TRANSPAD_GEN_MISS_CNT_EN
      check("t6.idle_hold", 64'(miss_cnt), 64'd3);
`endif
      beat(3'd7, 48'h0000_0000_00A5);
`ifdef TRANSPAD_GEN_MISS_CNT_EN
      check("t6.restart", 64'(miss_cnt), 64'd0);
`endif

      // Reset in the middle of RUN
      idle_cycle();
      lookup("t7.h0", 48'h00, 1'b1, 24'd0);
      rstn = 1'b0;
      idle_cycle();
      status("t7.reset", 1'b0, 1'b0, 1'b0);
      rstn = 1'b1;
      lookup("t7.after", 48'h00, 1'b0, 24'd0);

      check("sb.empty", 64'(sb.size()), 64'd0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/transpad_gen.md
Name: transpad_gen

Overview:
- Parametrised successor to the fixed 3-stream transpad datapath: one self-contained block with the control FSM, NS interleaved strided address streams, and a two-level (inner/outer) loop nest.
- Watches a lookup bus. When an address matches the next predicted stream address, it flags a scratchpad hit and returns a sequential scratchpad address.
- Sits between the host-side address/command bus and the scratchpad mapper.

Parameters:
AW, 48, address and data bus width
SW, 24, scratchpad address width
FW, 16, width of stride, offset, length and outer-offset fields; AW >= 2*FW+8 required
NS, 4, maximum interleaved streams (>= 1); stream index width IW = max(1, clog2(NS))

Ports:
clk  in  1  clock, rising edge
rstn  in  1  synchronous active-low reset
cmd  in  3  beat type: 0 st_addr, 1 mode/len, 2 outer, 3 stream cfg, 6 lookup, 7 control, others ignored
data  in  AW  config payload or lookup address
rdy  in  1  beat valid
spm  out  1  scratchpad hit (combinational)
out  out  SW  scratchpad address for hit (combinational)
busy  out  1  state is INIT or RUN
done  out  1  state is DONE
err  out  1  one-cycle pulse: rejected start or config write in INIT/RUN

Behaviour:
- Reset: FSM=IDLE; all config, target, counter and last-hit registers 0; lst_vld=0; spm=0, out=0, busy=0, done=0, err=0.
- Config beats (rdy and cmd 0..3) are accepted only in IDLE or DONE and take effect on the next edge.
  - cmd0: st_addr=data.
  - cmd1: nstr=data[FW+7:FW] (streams used), len=data[FW-1:0].
  - cmd2: oofs=data[2FW-1:FW], olen=data[FW-1:0].
  - cmd3: k=data[2FW+IW-1:2FW], str_k=data[2FW-1:FW], ofs_k=data[FW-1:0]; k >= NS is ignored.
  - Any config beat in INIT/RUN is ignored and pulses err.
- Control beats (rdy, cmd7):
  - data[7:0]=8'hA5 is start. It is valid only if 1 <= nstr <= NS, len != 0 and olen != 0.
  - A valid start in IDLE/DONE goes to INIT, sets base=st_addr, and clears spad, cur, icnt, ocnt and lst_vld.
  - An invalid start, or a start in INIT/RUN, pulses err and leaves the state unchanged.
  - data[7:0]=8'h5A is stop. From any state it goes to IDLE and clears lst_vld. Config registers are kept.
- FSM states and transitions:
  - IDLE -> INIT on valid start.
  - INIT -> RUN after exactly 1 cycle; loads t_k = base + ofs_k for all k < NS. Lookups in INIT return spm=0.
  - RUN -> DONE on the final hit.
  - DONE -> INIT on valid start.
  - Any state -> IDLE on stop.
- Lookup beats (rdy, cmd6):
  - tgt_hit = (state==RUN and data==t_cur).
  - lst_hit = (lst_vld and data==lst_addr).
  - spm = tgt_hit or lst_hit.
  - out = spad when tgt_hit; lst_spad when only lst_hit; 0 otherwise.
  - tgt_hit has priority when both match.
  - spm and out are 0 on any non-lookup cycle.
- On tgt_hit, the next edge does the following:
  - lst_addr=t_cur, lst_spad=spad, lst_vld=1.
  - t_cur += str_cur, spad += 1.
  - If cur == nstr-1: cur=0 and icnt += 1. Otherwise cur += 1.
- Inner loop end (icnt reaches len on this hit):
  - icnt=0, ocnt += 1, base += oofs.
  - If ocnt reaches olen: go to DONE. Otherwise reload t_k = base_new + ofs_k in the same edge, with no INIT cycle.
  - DONE is reached after exactly nstr*len*olen target hits.
- Arithmetic widths and wrap:
  - Address arithmetic is modulo 2^AW; stride, offset and oofs are zero-extended.
  - spad wraps modulo 2^SW.
  - icnt and ocnt are FW bits wide.
- In DONE, lst_hit remains serviced and target matching is disabled.
- Reset mid-operation returns every register to its reset value immediately on the edge.

Optional Feature:
- TRANSPAD_GEN_MISS_CNT_EN defined:
  - Adds output miss_cnt [FW-1:0]: count of lookup beats in RUN with spm=0.
  - Saturates at all-ones.
  - Cleared by valid start and by reset; held through stop, IDLE and DONE.
- Undefined: no port and no counter logic.

Test Plan:
- Config st_addr=0x1000, nstr=2, len=2, olen=1, str0=4, ofs0=0, str1=8, ofs1=0x100; start; lookups 0x1000, 0x1100, 0x1004, 0x1108 -> spm=1, out=0,1,2,3; done=1 after the 4th hit; busy=0.
- Same config; lookup 0x1100 first -> spm=0 (out of order), no state change. Then 0x1000 -> out=0. Repeat 0x1000 -> spm=1, out=0 (last-hit path, no advance).
- nstr=1, str0=0x10, len=2, olen=2, oofs=0x40, st_addr=0 -> hits at 0x0, 0x10, 0x40, 0x50 give out=0..3; DONE after the 4th hit.
- Start with nstr=0 or nstr=NS+1 or len=0 -> err pulse, state stays IDLE. Config write during RUN -> err pulse, register unchanged.
- Stop mid-RUN after 1 hit -> IDLE, lst_vld=0; lookup of the previous hit address -> spm=0. Re-start -> out restarts at 0.
- TRANSPAD_GEN_MISS_CNT_EN: 3 unmatched lookups in RUN -> miss_cnt=3. A lookup in IDLE does not count. Valid start -> 0.
